// File: rtl/mlp_conv_pkg.sv
// mlp_conv shared types and helpers.
// Result-path state encoding and signed saturation.
package mlp_conv_pkg;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  localparam int MAX_LANES = 5;

  // Sign-extend an acc_w-bit value, then clamp it to the signed out_w range.
  function automatic logic [63:0] saturate(
    input logic [63:0] v,
    input int          acc_w,
    input int          out_w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = $signed(v << (64 - acc_w)) >>> (64 - acc_w);
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/result_out_ctrl_fifo.sv
// First-word fall-through result FIFO.
// Registered head word, synchronous flush, occupancy count.
module out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FLUSH,
  input  logic                     PUSH,
  input  logic [WIDTH-1:0]         PUSH_DATA,
  input  logic                     POP,
  output logic [WIDTH-1:0]         RD_DATA,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] head_q;
  logic             do_pop;
  logic             do_push;

  assign EMPTY   = (count_q == '0);
  assign FULL    = (count_q == (AW+1)'(DEPTH));
  assign COUNT   = count_q;
  assign RD_DATA = head_q;
  assign rd_nxt  = rd_ptr + AW'(1);
  assign do_pop  = POP & ~EMPTY & ~FLUSH;
  assign do_push = PUSH & (~FULL | do_pop) & ~FLUSH;

  // Storage array, written on every accepted push.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= PUSH_DATA;
  end

  // Pointers and occupancy.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (FLUSH) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      if (do_push & ~do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop & ~do_push) count_q <= count_q - 1'b1;
    end
  end

  // Head word tracks the next entry; it holds its value once empty.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head_q <= '0;
    end else if (!FLUSH) begin
      if (do_pop) begin
        if (count_q > (AW+1)'(1)) head_q <= mem[rd_nxt];
        else if (do_push)         head_q <= PUSH_DATA;
      end else if (do_push && EMPTY) begin
        head_q <= PUSH_DATA;
      end
    end
  end

endmodule

// File: rtl/result_out_ctrl.sv
// Result row capture, saturation and serialisation.
// Feeds one lane per cycle into the output FIFO.
module result_out_ctrl
  import mlp_conv_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 32,
  parameter int ACC_WIDTH    = 40,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          CLEAR_FIFO,
  input  logic [3:0]                    PARAM_S,
  input  logic                          RES_VALID,
  output logic                          RES_READY,
  input  logic [ACC_WIDTH-1:0]          RES_DATA_0,
  input  logic [ACC_WIDTH-1:0]          RES_DATA_1,
  input  logic [ACC_WIDTH-1:0]          RES_DATA_2,
  input  logic [ACC_WIDTH-1:0]          RES_DATA_3,
  input  logic [ACC_WIDTH-1:0]          RES_DATA_4,
  input  logic                          FIFO_RD_CMD,
  output logic [OUTPUT_WIDTH-1:0]       FIFO_RD_DATA,
  output logic                          FIFO_EMPTY,
  output logic                          FIFO_FULL,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          SAT_FLAG,
  output logic                          BUSY
);

  state_t                state_q;
  state_t                state_d;
  logic [ACC_WIDTH-1:0]  lane_q [MAX_LANES];
  logic [ACC_WIDTH-1:0]  lane_cur;
  logic [2:0]            idx_q;
  logic [2:0]            n_q;
  logic [2:0]            n_clamp;
  logic                  clear_prev;
  logic                  clear_pulse;
  logic                  sat_q;
  logic                  capture;
  logic                  push;
  logic                  pop;
  logic                  last_lane;
  logic [63:0]           sat64;
  logic [63:0]           lane_sx;
  logic                  lane_sat;

  assign RES_READY = (state_q == IDLE) & ~clear_pulse & ~RESET;
  assign BUSY      = (state_q == DRAIN);
  assign SAT_FLAG  = sat_q;
  assign capture   = RES_VALID & RES_READY;
  assign pop       = FIFO_RD_CMD & ~FIFO_EMPTY & ~clear_pulse;
  assign push      = BUSY & ~clear_pulse & (~FIFO_FULL | pop);
  assign last_lane = (idx_q == 3'(n_q - 3'd1));
  assign sat64     = saturate(64'(lane_cur), ACC_WIDTH, OUTPUT_WIDTH);
  assign lane_sx   = 64'($signed(lane_cur));
  assign lane_sat  = (sat64 != lane_sx);

  // Clamp the requested row length into 1..MAX_LANES.
  always_comb begin
    n_clamp = PARAM_S[2:0];
    if (PARAM_S == 4'd0)      n_clamp = 3'd1;
    else if (PARAM_S > 4'd5)  n_clamp = 3'd5;
  end

  // Select the lane currently being serialised.
  always_comb begin
    lane_cur = lane_q[0];
    unique case (idx_q)
      3'd1:    lane_cur = lane_q[1];
      3'd2:    lane_cur = lane_q[2];
      3'd3:    lane_cur = lane_q[3];
      3'd4:    lane_cur = lane_q[4];
      default: lane_cur = lane_q[0];
    endcase
  end

  // Next state: leave DRAIN after the last lane, abort on clear.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (capture) state_d = DRAIN;
      DRAIN:   if (push && last_lane) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_pulse) state_d = IDLE;
  end

  // State, edge detect for clear, and sticky saturation flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      clear_prev  <= 1'b0;
      clear_pulse <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_prev  <= CLEAR_FIFO;
      clear_pulse <= CLEAR_FIFO & ~clear_prev;
      if (clear_pulse)          sat_q <= 1'b0;
      else if (push & lane_sat) sat_q <= 1'b1;
    end
  end

  // Holding register and lane index for the captured row.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx_q <= '0;
      n_q   <= 3'd1;
      for (int i = 0; i < MAX_LANES; i++) lane_q[i] <= '0;
    end else if (capture) begin
      idx_q     <= '0;
      n_q       <= n_clamp;
      lane_q[0] <= RES_DATA_0;
      lane_q[1] <= RES_DATA_1;
      lane_q[2] <= RES_DATA_2;
      lane_q[3] <= RES_DATA_3;
      lane_q[4] <= RES_DATA_4;
    end else if (push) begin
      idx_q <= last_lane ? 3'd0 : idx_q + 3'd1;
    end
  end

  out_fifo #(
    .WIDTH (OUTPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (clear_pulse),
    .PUSH      (push),
    .PUSH_DATA (sat64[OUTPUT_WIDTH-1:0]),
    .POP       (pop),
    .RD_DATA   (FIFO_RD_DATA),
    .EMPTY     (FIFO_EMPTY),
    .FULL      (FIFO_FULL),
    .COUNT     (FIFO_COUNT)
  );

endmodule
